// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults (640x480@60) and helpers used by the framebuffer
// scanout and renderer tops.
package video_timing_pkg;

    localparam int DEF_HOR_ACTIVE = 640;
    localparam int DEF_HOR_FP     = 16;
    localparam int DEF_HOR_SYNC   = 96;
    localparam int DEF_HOR_BP     = 48;
    localparam int DEF_VER_ACTIVE = 480;
    localparam int DEF_VER_FP     = 10;
    localparam int DEF_VER_SYNC   = 2;
    localparam int DEF_VER_BP     = 33;

    localparam logic DEF_SYNC_ACTIVE = 1'b0;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/frame_scanout_if.sv
// Framebuffer read port: scanout is the master, the buffer memory the slave.
interface frame_scanout_if #(
    parameter int ADDR_W = 20
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/video_timing_gen.sv
// Raster h/v counters with combinational active/sync decode and the frame-wrap
// and buffer-flip strobes, all qualified by the pixel strobe.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int   HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE,
    parameter int   HOR_FRONT_PORCH   = DEF_HOR_FP,
    parameter int   HOR_SYNC_PULSE    = DEF_HOR_SYNC,
    parameter int   HOR_BACK_PORCH    = DEF_HOR_BP,
    parameter int   VER_ACTIVE_PIXELS = DEF_VER_ACTIVE,
    parameter int   VER_FRONT_PORCH   = DEF_VER_FP,
    parameter int   VER_SYNC_PULSE    = DEF_VER_SYNC,
    parameter int   VER_BACK_PORCH    = DEF_VER_BP,
    parameter logic SYNC_ACTIVE       = DEF_SYNC_ACTIVE
) (
    input  logic clk,
    input  logic rst,
    input  logic i_ce,
    output logic o_active,
    output logic o_hsync,
    output logic o_vsync,
    output logic o_frame_wrap,
    output logic o_flip_point
);

    localparam int H_TOTAL = h_total(HOR_ACTIVE_PIXELS, HOR_FRONT_PORCH, HOR_SYNC_PULSE, HOR_BACK_PORCH);
    localparam int V_TOTAL = v_total(VER_ACTIVE_PIXELS, VER_FRONT_PORCH, VER_SYNC_PULSE, VER_BACK_PORCH);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam int H_SYNC_BEG = HOR_ACTIVE_PIXELS + HOR_FRONT_PORCH;
    localparam int H_SYNC_END = H_SYNC_BEG + HOR_SYNC_PULSE;
    localparam int V_SYNC_BEG = VER_ACTIVE_PIXELS + VER_FRONT_PORCH;
    localparam int V_SYNC_END = V_SYNC_BEG + VER_SYNC_PULSE;

    logic [HW-1:0] r_h_cnt;
    logic [VW-1:0] r_v_cnt;
    logic          w_h_last;
    logic          w_v_last;
    int            w_h;
    int            w_v;

    assign w_h      = int'(r_h_cnt);
    assign w_v      = int'(r_v_cnt);
    assign w_h_last = (w_h == H_TOTAL - 1);
    assign w_v_last = (w_v == V_TOTAL - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (i_ce) begin
            if (w_h_last) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_last ? '0 : r_v_cnt + VW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + HW'(1);
            end
        end
    end

    // Line layout: active, front porch, sync, back porch (same order vertically).
    assign o_active     = (w_h < HOR_ACTIVE_PIXELS) && (w_v < VER_ACTIVE_PIXELS);
    assign o_hsync      = (w_h >= H_SYNC_BEG && w_h < H_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_vsync      = (w_v >= V_SYNC_BEG && w_v < V_SYNC_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_frame_wrap = i_ce && w_h_last && w_v_last;
    assign o_flip_point = i_ce && (w_h == 0) && (w_v == VER_ACTIVE_PIXELS);

endmodule

// File: rtl/frame_scanout.sv
// Scanout of a 1-bpp double-buffered framebuffer: raster timing, pixel reads,
// aligned video outputs and the front/back buffer flip at vblank start.
module frame_scanout
    import video_timing_pkg::*;
#(
    parameter int   HOR_ACTIVE_PIXELS = DEF_HOR_ACTIVE,
    parameter int   HOR_FRONT_PORCH   = DEF_HOR_FP,
    parameter int   HOR_SYNC_PULSE    = DEF_HOR_SYNC,
    parameter int   HOR_BACK_PORCH    = DEF_HOR_BP,
    parameter int   VER_ACTIVE_PIXELS = DEF_VER_ACTIVE,
    parameter int   VER_FRONT_PORCH   = DEF_VER_FP,
    parameter int   VER_SYNC_PULSE    = DEF_VER_SYNC,
    parameter int   VER_BACK_PORCH    = DEF_VER_BP,
    parameter logic SYNC_ACTIVE       = DEF_SYNC_ACTIVE
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce,
    input  logic                   frame_ready,
    frame_scanout_if.master        fb,
    output logic                   swap,
    output logic                   front_buf,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   pixel
);

    localparam int ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS);

    logic                  w_active;
    logic                  w_hsync;
    logic                  w_vsync;
    logic                  w_frame_wrap;
    logic                  w_flip_point;
    logic                  w_flip;

    logic [ADDR_WIDTH-1:0] r_pix_addr;
    logic                  r_front_buf;
    logic                  r_swap;
    logic                  r_active_d;
    logic                  r_hsync_d;
    logic                  r_vsync_d;
    logic                  r_de;
    logic                  r_pixel;
    logic                  r_hsync;
    logic                  r_vsync;

    video_timing_gen #(
        .HOR_ACTIVE_PIXELS (HOR_ACTIVE_PIXELS),
        .HOR_FRONT_PORCH   (HOR_FRONT_PORCH),
        .HOR_SYNC_PULSE    (HOR_SYNC_PULSE),
        .HOR_BACK_PORCH    (HOR_BACK_PORCH),
        .VER_ACTIVE_PIXELS (VER_ACTIVE_PIXELS),
        .VER_FRONT_PORCH   (VER_FRONT_PORCH),
        .VER_SYNC_PULSE    (VER_SYNC_PULSE),
        .VER_BACK_PORCH    (VER_BACK_PORCH),
        .SYNC_ACTIVE       (SYNC_ACTIVE)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .i_ce         (ce),
        .o_active     (w_active),
        .o_hsync      (w_hsync),
        .o_vsync      (w_vsync),
        .o_frame_wrap (w_frame_wrap),
        .o_flip_point (w_flip_point)
    );

    // Flip only on the first blank line, so the front buffer is stable over active video.
    assign w_flip = w_flip_point && frame_ready;

    // Stage 0: read request for the current raster position; memory answers next clk.
    assign fb.rd_en   = ce && w_active && !rst;
    assign fb.rd_addr = {r_front_buf, r_pix_addr};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pix_addr  <= '0;
            r_front_buf <= 1'b0;
            r_swap      <= 1'b0;
            r_active_d  <= 1'b0;
            r_hsync_d   <= ~SYNC_ACTIVE;
            r_vsync_d   <= ~SYNC_ACTIVE;
            r_de        <= 1'b0;
            r_pixel     <= 1'b0;
            r_hsync     <= ~SYNC_ACTIVE;
            r_vsync     <= ~SYNC_ACTIVE;
        end else begin
            r_swap <= w_flip;
            if (w_flip) begin
                r_front_buf <= ~r_front_buf;
            end
            if (ce) begin
                if (w_frame_wrap) begin
                    r_pix_addr <= '0;
                end else if (w_active) begin
                    r_pix_addr <= r_pix_addr + ADDR_WIDTH'(1);
                end
                r_active_d <= w_active;
                r_hsync_d  <= w_hsync;
                r_vsync_d  <= w_vsync;
                // Stage 1: read data has arrived; all four outputs move together.
                r_de       <= r_active_d;
                r_pixel    <= r_active_d & fb.rd_data;
                r_hsync    <= r_hsync_d;
                r_vsync    <= r_vsync_d;
            end
        end
    end

    assign swap      = r_swap;
    assign front_buf = r_front_buf;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;
    assign de        = r_de;
    assign pixel     = r_pixel;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout at 8x4 active (12 clk lines, 7-line frames) with a
// positional reference model and a behavioural framebuffer memory.
module tb_frame_scanout;

    localparam int HA = 8, HT = 12, VA = 4, FR = 84;

    logic clk, rst, ce, frame_ready;
    logic swap, front_buf, hsync, vsync, de, pixel;
    logic mem [64];

    frame_scanout_if #(.ADDR_W(6)) fb ();

    frame_scanout #(
        .HOR_ACTIVE_PIXELS (8), .HOR_FRONT_PORCH (1), .HOR_SYNC_PULSE (2), .HOR_BACK_PORCH (1),
        .VER_ACTIVE_PIXELS (4), .VER_FRONT_PORCH (1), .VER_SYNC_PULSE (1), .VER_BACK_PORCH (1),
        .SYNC_ACTIVE       (1'b0)
    ) dut (
        .clk (clk), .rst (rst), .ce (ce), .frame_ready (frame_ready), .fb (fb),
        .swap (swap), .front_buf (front_buf), .hsync (hsync), .vsync (vsync),
        .de (de), .pixel (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (fb.rd_en) fb.rd_data <= mem[fb.rd_addr];

    int n_err = 0;
    int n_chk = 0;

    // Reference model: ce ticks since reset and the buffer currently shown.
    int         m_n;
    bit         m_fb;
    bit         pend_de, pend_hs, pend_vs, pend_pix;
    bit         e_de, e_hs, e_vs, e_pix, e_swap, e_fb, e_rden;
    logic [5:0] e_addr;
    logic       s_rd_en;
    logic [5:0] s_rd_addr;

    task automatic step(input bit c, input bit r, input bit rs);
        int p, h, v;
        bit act;
        @(negedge clk);
        ce = c; frame_ready = r; rst = rs;
        p = m_n % FR; h = p % HT; v = p / HT;
        act = (h < HA) && (v < VA);
        #1;
        s_rd_en   = fb.rd_en;
        s_rd_addr = fb.rd_addr;
        e_rden = c && !rs && act;
        e_addr = {m_fb, 5'(v * HA + h)};
        @(posedge clk);
        #1;
        e_swap = 1'b0;
        if (rs) begin
            m_n = 0; m_fb = 1'b0;
            pend_de = 0; pend_hs = 1; pend_vs = 1; pend_pix = 0;
            e_de = 0; e_hs = 1; e_vs = 1; e_pix = 0;
        end else if (c) begin
            e_de = pend_de; e_hs = pend_hs; e_vs = pend_vs; e_pix = pend_pix;
            pend_de  = act;
            pend_hs  = !(h >= 9 && h < 11);
            pend_vs  = (v != 5);
            pend_pix = act ? mem[{m_fb, 5'(v * HA + h)}] : 1'b0;
            if (h == 0 && v == VA && r) begin
                m_fb   = !m_fb;
                e_swap = 1'b1;
            end
            m_n++;
        end
        e_fb = m_fb;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic fill_mem(input bit pattern);
        for (int a = 0; a < 64; a++) mem[a] = pattern ? a[0] : 1'($urandom);
    endtask

    task automatic test_reset();
        fill_mem(1'b0);
        do_reset(3);
        n_chk++; if (hsync !== 1'b1) begin n_err++; $display("FAIL reset_hsync got=%b want=1", hsync); end
        n_chk++; if (vsync !== 1'b1) begin n_err++; $display("FAIL reset_vsync got=%b want=1", vsync); end
        n_chk++; if (de !== 1'b0) begin n_err++; $display("FAIL reset_de got=%b want=0", de); end
        n_chk++; if (pixel !== 1'b0) begin n_err++; $display("FAIL reset_pixel got=%b want=0", pixel); end
        n_chk++; if (swap !== 1'b0) begin n_err++; $display("FAIL reset_swap got=%b want=0", swap); end
        n_chk++; if (front_buf !== 1'b0) begin n_err++; $display("FAIL reset_front_buf got=%b want=0", front_buf); end
        n_chk++; if (s_rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en got=%b want=0", s_rd_en); end
    endtask

    task automatic test_timing();
        int n_de, n_hs, n_vs, de_rise0, de_rise1, vs_fall0, vs_fall1;
        logic de_prev, vs_prev;
        fill_mem(1'b0);
        do_reset(2);
        n_de = 0; n_hs = 0; n_vs = 0;
        de_rise0 = -1; de_rise1 = -1; vs_fall0 = -1; vs_fall1 = -1;
        de_prev = 1'b0; vs_prev = 1'b1;
        for (int i = 0; i < 2 * FR + 2; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_chk++;
            if (de !== e_de || hsync !== e_hs || vsync !== e_vs) begin
                n_err++;
                $display("FAIL timing_tick%0d de/hs/vs=%b%b%b want %b%b%b", i, de, hsync, vsync, e_de, e_hs, e_vs);
            end
            if (i >= 1 && i <= FR) begin
                n_de += (de === 1'b1); n_hs += (hsync === 1'b0); n_vs += (vsync === 1'b0);
            end
            if (de === 1'b1 && de_prev === 1'b0) begin
                if (de_rise0 < 0) de_rise0 = i; else if (de_rise1 < 0) de_rise1 = i;
            end
            if (vsync === 1'b0 && vs_prev === 1'b1) begin
                if (vs_fall0 < 0) vs_fall0 = i; else if (vs_fall1 < 0) vs_fall1 = i;
            end
            de_prev = de; vs_prev = vsync;
        end
        n_chk++; if (n_de != 32) begin n_err++; $display("FAIL de_per_frame got=%0d want=32", n_de); end
        n_chk++; if (n_hs != 14) begin n_err++; $display("FAIL hsync_low_per_frame got=%0d want=14", n_hs); end
        n_chk++; if (n_vs != 12) begin n_err++; $display("FAIL vsync_low_per_frame got=%0d want=12", n_vs); end
        n_chk++; if (de_rise1 - de_rise0 != 12) begin n_err++; $display("FAIL line_length got=%0d want=12", de_rise1 - de_rise0); end
        n_chk++; if (vs_fall1 - vs_fall0 != 84) begin n_err++; $display("FAIL frame_length got=%0d want=84", vs_fall1 - vs_fall0); end
    endtask

    task automatic test_data();
        int amin, amax, n_one;
        fill_mem(1'b1);
        do_reset(2);
        amin = 99; amax = -1; n_one = 0;
        for (int i = 0; i < FR + 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            n_chk++;
            if (s_rd_en !== e_rden || (e_rden && s_rd_addr !== e_addr)) begin
                n_err++;
                $display("FAIL read_tick%0d rd_en=%b addr=%0d want rd_en=%b addr=%0d", i, s_rd_en, s_rd_addr, e_rden, e_addr);
            end
            n_chk++;
            if (pixel !== e_pix || de !== e_de) begin
                n_err++;
                $display("FAIL pixel_tick%0d pixel/de=%b%b want %b%b", i, pixel, de, e_pix, e_de);
            end
            if (i < FR && s_rd_en === 1'b1) begin
                if (int'(s_rd_addr[4:0]) < amin) amin = int'(s_rd_addr[4:0]);
                if (int'(s_rd_addr[4:0]) > amax) amax = int'(s_rd_addr[4:0]);
            end
            if (i >= 1 && i <= FR) n_one += (pixel === 1'b1);
        end
        n_chk++; if (amin != 0 || amax != 31) begin n_err++; $display("FAIL addr_span got=%0d..%0d want=0..31", amin, amax); end
        n_chk++; if (n_one != 16) begin n_err++; $display("FAIL pixel_ones got=%0d want=16", n_one); end
    endtask

    task automatic test_flip(input bit ready_at_flip);
        int n_swap, pos;
        bit rdy;
        fill_mem(1'b0);
        do_reset(2);
        n_swap = 0;
        for (int i = 0; i < 3 * FR; i++) begin
            pos = m_n;
            rdy = ready_at_flip ? 1'b1 : ((pos % FR == 48) ? 1'b0 : 1'($urandom));
            step(1'b1, rdy, 1'b0);
            n_chk++;
            if (swap !== e_swap || front_buf !== e_fb) begin
                n_err++;
                $display("FAIL flip_tick%0d swap/front_buf=%b%b want %b%b", i, swap, front_buf, e_swap, e_fb);
            end
            n_chk++;
            if (s_rd_en !== e_rden || (e_rden && s_rd_addr !== e_addr)) begin
                n_err++;
                $display("FAIL flip_addr_tick%0d rd_en=%b addr=%0d want rd_en=%b addr=%0d", i, s_rd_en, s_rd_addr, e_rden, e_addr);
            end
            n_swap += (swap === 1'b1);
            if (pos % FR == 0) begin
                n_chk++;
                if (s_rd_addr[5] !== (ready_at_flip ? 1'((pos / FR) % 2) : 1'b0)) begin
                    n_err++;
                    $display("FAIL frame%0d_buffer_bit got=%b", pos / FR, s_rd_addr[5]);
                end
            end
        end
        n_chk++;
        if (n_swap != (ready_at_flip ? 3 : 0)) begin
            n_err++;
            $display("FAIL swap_count got=%0d want=%0d", n_swap, ready_at_flip ? 3 : 0);
        end
    endtask

    task automatic test_ce_reset();
        bit c, rs, rst_done, first_seen;
        fill_mem(1'b0);
        do_reset(2);
        rst_done = 0; first_seen = 0;
        for (int i = 0; i < 900; i++) begin
            c  = (i % 3 == 0);
            rs = c && !rst_done && (m_n == FR + 29);
            if (rs) begin
                n_chk++;
                if (front_buf !== 1'b1) begin n_err++; $display("FAIL pre_reset_front_buf got=%b want=1", front_buf); end
            end
            step(c, 1'b1, rs);
            n_chk++;
            if (de !== e_de || hsync !== e_hs || vsync !== e_vs || pixel !== e_pix ||
                swap !== e_swap || front_buf !== e_fb ||
                s_rd_en !== e_rden || (e_rden && s_rd_addr !== e_addr)) begin
                n_err++;
                $display("FAIL ce3_clk%0d de/hs/vs/px/sw/fb/rden=%b%b%b%b%b%b%b addr=%0d want %b%b%b%b%b%b%b addr=%0d",
                         i, de, hsync, vsync, pixel, swap, front_buf, s_rd_en, s_rd_addr,
                         e_de, e_hs, e_vs, e_pix, e_swap, e_fb, e_rden, e_addr);
            end
            if (rs) begin
                rst_done = 1;
                n_chk++;
                if (front_buf !== 1'b0) begin n_err++; $display("FAIL post_reset_front_buf got=%b want=0", front_buf); end
            end else if (rst_done && !first_seen && s_rd_en === 1'b1) begin
                first_seen = 1;
                n_chk++;
                if (s_rd_addr !== 6'd0) begin n_err++; $display("FAIL restart_addr got=%0d want=0", s_rd_addr); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; frame_ready = 1'b0;
        m_n = 0; m_fb = 1'b0;
        test_reset();
        test_timing();
        test_data();
        test_flip(1'b1);
        test_flip(1'b0);
        test_ce_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
